// File: rtl/period_generator.sv
// Square-wave generator: code P gives a 50%-duty output of P+1 clocks.
// New periods take effect only on the rising edge of out.
module period_generator #(
  parameter int WIDTH      = 32,
  parameter int MIN_PERIOD = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] period_in,
  input  logic             period_load,
  output logic             out,
  output logic             cycle_start,
  output logic             active,
  output logic [WIDTH-1:0] period_active
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [WIDTH-1:0] MIN_CODE = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t state, state_n;

  logic [WIDTH-1:0] phase_cnt, phase_cnt_n;
  logic [WIDTH-1:0] pending, pending_n;
  logic [WIDTH-1:0] period_n;
  logic             pending_valid, pending_valid_n;
  logic             have_period, have_period_n;
  logic             out_n, cycle_start_n;
  logic [WIDTH-1:0] load_val, next_code;
  logic             boundary, phase_end;

  // (P+1)>>1 without needing a WIDTH+1 bit sum
  function automatic logic [WIDTH-1:0] half(input logic [WIDTH-1:0] p);
    return (p >> 1) + {{(WIDTH-1){1'b0}}, p[0]};
  endfunction

  assign load_val  = (period_in < MIN_CODE) ? MIN_CODE : period_in;
  assign next_code = period_load   ? load_val :
                     pending_valid ? pending  : period_active;
  assign phase_end = (phase_cnt == '0);
  assign active    = (state != IDLE);

  always_comb begin
    state_n         = state;
    phase_cnt_n     = phase_cnt;
    pending_n       = pending;
    pending_valid_n = pending_valid;
    have_period_n   = have_period;
    period_n        = period_active;
    out_n           = 1'b0;
    cycle_start_n   = 1'b0;
    boundary        = 1'b0;

    unique case (state)
      IDLE: begin
        boundary = enable &&
          (pending_valid || period_load || have_period);
      end
      HIGH: begin
        if (phase_end) begin
          state_n = LOW;
          // L-1 = N-H-1 = P-H
          phase_cnt_n = period_active - half(period_active);
        end else begin
          out_n       = 1'b1;
          phase_cnt_n = phase_cnt - ONE;
        end
      end
      LOW: begin
        if (phase_end) begin
          if (enable) boundary = 1'b1;
          else        state_n  = IDLE;
        end else begin
          phase_cnt_n = phase_cnt - ONE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (boundary) begin
      state_n         = HIGH;
      out_n           = 1'b1;
      cycle_start_n   = 1'b1;
      period_n        = next_code;
      phase_cnt_n     = half(next_code) - ONE;
      pending_valid_n = 1'b0;
      have_period_n   = 1'b1;
    end else if (period_load) begin
      pending_n       = load_val;
      pending_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      phase_cnt     <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      have_period   <= 1'b0;
      period_active <= '0;
      out           <= 1'b0;
      cycle_start   <= 1'b0;
    end else begin
      state         <= state_n;
      phase_cnt     <= phase_cnt_n;
      pending       <= pending_n;
      pending_valid <= pending_valid_n;
      have_period   <= have_period_n;
      period_active <= period_n;
      out           <= out_n;
      cycle_start   <= cycle_start_n;
    end
  end

endmodule
